// File: rtl/bats_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bats_unit_arbiter
// Brief    : Packet-atomic round-robin arbiter feeding the single BATS parser
//            UDP input from N_UNITS unit feeds. It forwards each word through a
//            one-entry output register and checks the byte count of each
//            packet against its header length.
// Revision : 1.0 - initial release
// ============================================================================
module bats_unit_arbiter #(
   parameter int N_UNITS     = 4,
   parameter int TIMEOUT_CYC = 255,
   parameter int CNT_W       = 16
) (
   input  logic                  Clk40,
   input  logic                  reset_n,
   input  logic [N_UNITS-1:0]    src_valid,
   input  logic [N_UNITS-1:0]    src_last,
   input  logic [64*N_UNITS-1:0] src_bytes,
   input  logic [8*N_UNITS-1:0]  src_byte_en,
   output logic [N_UNITS-1:0]    src_ready,
   input  logic                  par_ready,
   output logic                  par_data_valid,
   output logic [63:0]           par_bytes,
   output logic [7:0]            par_byte_en,
   output logic [2:0]            grant_id,
   output logic                  busy,
   output logic                  len_err,
   output logic                  timeout_err,
   output logic [CNT_W-1:0]      len_err_cnt,
   output logic [CNT_W-1:0]      timeout_err_cnt
);

   localparam int IDLE_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t             state_q,       state_d;
   logic [2:0]         grant_q,       grant_d;
   logic [2:0]         rr_ptr_q,      rr_ptr_d;
   logic               out_valid_q,   out_valid_d;
   logic [63:0]        out_bytes_q,   out_bytes_d;
   logic [7:0]         out_be_q,      out_be_d;
   logic               first_q,       first_d;
   logic [15:0]        hdr_len_q,     hdr_len_d;
   logic [CNT_W-1:0]   byte_cnt_q,    byte_cnt_d;
   logic [IDLE_W-1:0]  idle_cnt_q,    idle_cnt_d;
   logic               len_err_q,     len_err_d;
   logic               timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]   len_cnt_q,     len_cnt_d;
   logic [CNT_W-1:0]   to_cnt_q,      to_cnt_d;

   // Per-feed views padded to 8 entries so a 3-bit grant index always fits
   logic [7:0]         valid_pad;
   logic [7:0]         last_pad;
   logic [63:0]        bytes_arr [8];
   logic [7:0]         be_arr    [8];

   logic               win_found;
   logic [2:0]         win_idx;
   logic [3:0]         cand;
   logic               w_can_take;
   logic               w_accept;
   logic               w_g_valid;
   logic               w_g_last;
   logic [63:0]        w_word;
   logic [7:0]         w_be;
   logic [3:0]         w_pc;
   logic [15:0]        w_hdr;
   logic [CNT_W-1:0]   w_total;
   logic [2:0]         w_next_ptr;

   function automatic logic [3:0] popcnt8(input logic [7:0] v);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 0; i < 8; i++) begin
         s = s + {3'b000, v[i]};
      end
      return s;
   endfunction

   generate
      for (genvar i = 0; i < 8; i++) begin : g_feed
         if (i < N_UNITS) begin : g_used
            assign valid_pad[i] = src_valid[i];
            assign last_pad[i]  = src_last[i];
            assign bytes_arr[i] = src_bytes[64*i +: 64];
            assign be_arr[i]    = src_byte_en[8*i +: 8];
         end else begin : g_unused
            assign valid_pad[i] = 1'b0;
            assign last_pad[i]  = 1'b0;
            assign bytes_arr[i] = 64'd0;
            assign be_arr[i]    = 8'd0;
         end
      end
   endgenerate

   // Only the granted feed may move a word, and only when the output slot frees up
   assign w_can_take = (state_q == ST_XFER) && (!out_valid_q || par_ready);

   generate
      for (genvar i = 0; i < N_UNITS; i++) begin : g_ready
         assign src_ready[i] = w_can_take && (grant_q == 3'(i));
      end
   endgenerate

   // Round-robin search: lowest offset from the pointer wins, so scan offsets downward
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 4'd0;
      for (int k = N_UNITS - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + 4'(k);
         if (cand >= 4'(N_UNITS)) begin
            cand = cand - 4'(N_UNITS);
         end
         if (valid_pad[cand[2:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[2:0];
         end
      end
   end

   // Datapath of the granted feed and the running length check
   always_comb begin
      w_g_valid  = valid_pad[grant_q];
      w_g_last   = last_pad[grant_q];
      w_word     = bytes_arr[grant_q];
      w_be       = be_arr[grant_q];
      w_accept   = w_can_take && w_g_valid;
      w_pc       = popcnt8(w_be);
      // Header length is little-endian in the first two bytes of the packet
      w_hdr      = first_q ? {w_word[55:48], w_word[63:56]} : hdr_len_q;
      w_total    = (first_q ? {CNT_W{1'b0}} : byte_cnt_q) + CNT_W'(w_pc);
      w_next_ptr = (grant_q == 3'(N_UNITS - 1)) ? 3'd0 : grant_q + 3'd1;
   end

   // Next-state logic for the grant FSM, output register and error counters
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      out_valid_d   = out_valid_q;
      out_bytes_d   = out_bytes_q;
      out_be_d      = out_be_q;
      first_d       = first_q;
      hdr_len_d     = hdr_len_q;
      byte_cnt_d    = byte_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      len_err_d     = 1'b0;
      timeout_err_d = 1'b0;
      len_cnt_d     = len_cnt_q;
      to_cnt_d      = to_cnt_q;

      // Output slot: a new word overrides the drain, otherwise par_ready empties it
      if (w_accept) begin
         out_valid_d = 1'b1;
         out_bytes_d = w_word;
         out_be_d    = w_be;
      end else if (par_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d    = ST_XFER;
               grant_d    = win_idx;
               first_d    = 1'b1;
               byte_cnt_d = {CNT_W{1'b0}};
               idle_cnt_d = {IDLE_W{1'b0}};
            end
         end
         ST_XFER: begin
            if (w_accept) begin
               first_d    = 1'b0;
               hdr_len_d  = w_hdr;
               byte_cnt_d = w_total;
               idle_cnt_d = {IDLE_W{1'b0}};
               if (w_g_last) begin
                  len_err_d = (w_total != CNT_W'(w_hdr));
                  state_d   = ST_IDLE;
                  rr_ptr_d  = w_next_ptr;
               end
            end else if (!w_g_valid) begin
               if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                  timeout_err_d = 1'b1;
                  state_d       = ST_IDLE;
                  rr_ptr_d      = w_next_ptr;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (len_err_d && (len_cnt_q != {CNT_W{1'b1}})) begin
         len_cnt_d = len_cnt_q + 1'b1;
      end
      if (timeout_err_d && (to_cnt_q != {CNT_W{1'b1}})) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   // State and output registers; reset discards any packet in flight silently
   always_ff @(posedge Clk40 or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= 3'd0;
         rr_ptr_q      <= 3'd0;
         out_valid_q   <= 1'b0;
         out_bytes_q   <= 64'd0;
         out_be_q      <= 8'd0;
         first_q       <= 1'b0;
         hdr_len_q     <= 16'd0;
         byte_cnt_q    <= {CNT_W{1'b0}};
         idle_cnt_q    <= {IDLE_W{1'b0}};
         len_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         len_cnt_q     <= {CNT_W{1'b0}};
         to_cnt_q      <= {CNT_W{1'b0}};
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         out_valid_q   <= out_valid_d;
         out_bytes_q   <= out_bytes_d;
         out_be_q      <= out_be_d;
         first_q       <= first_d;
         hdr_len_q     <= hdr_len_d;
         byte_cnt_q    <= byte_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         len_err_q     <= len_err_d;
         timeout_err_q <= timeout_err_d;
         len_cnt_q     <= len_cnt_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   assign par_data_valid  = out_valid_q;
   assign par_bytes       = out_bytes_q;
   assign par_byte_en     = out_be_q;
   assign grant_id        = grant_q;
   assign busy            = (state_q == ST_XFER);
   assign len_err         = len_err_q;
   assign timeout_err     = timeout_err_q;
   assign len_err_cnt     = len_cnt_q;
   assign timeout_err_cnt = to_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bats_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bats_unit_arbiter
// Brief    : Directed self-checking bench for bats_unit_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bats_unit_arbiter;

   localparam int N  = 4;
   localparam int TO = 255;
   localparam int CW = 16;

   typedef struct packed {
      logic [63:0] b;
      logic [7:0]  be;
      logic        last;
   } word_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      src_valid;
   logic [N-1:0]      src_last;
   logic [64*N-1:0]   src_bytes;
   logic [8*N-1:0]    src_byte_en;
   logic [N-1:0]      src_ready;
   logic              par_ready;
   logic              par_data_valid;
   logic [63:0]       par_bytes;
   logic [7:0]        par_byte_en;
   logic [2:0]        grant_id;
   logic              busy;
   logic              len_err;
   logic              timeout_err;
   logic [CW-1:0]     len_err_cnt;
   logic [CW-1:0]     timeout_err_cnt;

   int                vectors = 0;
   int                errors  = 0;
   int                cyc     = 0;

   word_t             fmem [N][8];
   int                fcnt [N];
   int                fptr [N];
   logic [71:0]       rx_q[$];
   int                rx_cyc[$];
   logic [71:0]       exp_q[$];
   int                acc_log[$];
   int                exp_ord[$];
   int                len_pulses = 0;
   int                to_pulses  = 0;
   int                to_cyc     = 0;
   logic              busy_at_to = 1'b1;
   logic [71:0]       held;

   always #5 clk = ~clk;

   bats_unit_arbiter #(
      .N_UNITS     (N),
      .TIMEOUT_CYC (TO),
      .CNT_W       (CW)
   ) u_dut (
      .Clk40           (clk),
      .reset_n         (rst_n),
      .src_valid       (src_valid),
      .src_last        (src_last),
      .src_bytes       (src_bytes),
      .src_byte_en     (src_byte_en),
      .src_ready       (src_ready),
      .par_ready       (par_ready),
      .par_data_valid  (par_data_valid),
      .par_bytes       (par_bytes),
      .par_byte_en     (par_byte_en),
      .grant_id        (grant_id),
      .busy            (busy),
      .len_err         (len_err),
      .timeout_err     (timeout_err),
      .len_err_cnt     (len_err_cnt),
      .timeout_err_cnt (timeout_err_cnt)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Parser-side monitor: words handed over and error pulses
   always @(negedge clk) begin
      if (par_data_valid && par_ready) begin
         rx_q.push_back({par_bytes, par_byte_en});
         rx_cyc.push_back(cyc);
      end
      if (len_err) len_pulses++;
      if (timeout_err) begin
         to_pulses++;
         to_cyc     = cyc;
         busy_at_to = busy;
      end
   end

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic put(input int f, input logic [63:0] wb, input logic [7:0] wbe, input logic wl);
      fmem[f][fcnt[f]] = '{b: wb, be: wbe, last: wl};
      fcnt[f]++;
   endtask

   // 14-byte two-word packet whose header says 14
   task automatic pkt14(input int f);
      put(f, {8'h0e, 8'h00, 8'(f), 8'h01, 32'h0}, 8'hFF, 1'b0);
      put(f, {8'(f), 8'hA0, 48'h0}, 8'hFC, 1'b1);
   endtask

   task automatic exp_for(input int f);
      for (int i = 0; i < fcnt[f]; i++) begin
         exp_q.push_back({fmem[f][i].b, fmem[f][i].be});
         exp_ord.push_back(f);
      end
   endtask

   task automatic clear_all();
      for (int f = 0; f < N; f++) begin
         fcnt[f] = 0;
         fptr[f] = 0;
      end
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
      acc_log.delete();
      exp_ord.delete();
      len_pulses = 0;
      to_pulses  = 0;
   endtask

   function automatic int remaining();
      int r;
      r = 0;
      for (int f = 0; f < N; f++) r += fcnt[f] - fptr[f];
      return r;
   endfunction

   task automatic drive();
      for (int f = 0; f < N; f++) begin
         if (fptr[f] < fcnt[f]) begin
            src_valid[f]          = 1'b1;
            src_last[f]           = fmem[f][fptr[f]].last;
            src_bytes[64*f +: 64] = fmem[f][fptr[f]].b;
            src_byte_en[8*f +: 8] = fmem[f][fptr[f]].be;
         end else begin
            src_valid[f]          = 1'b0;
            src_last[f]           = 1'b0;
            src_bytes[64*f +: 64] = 64'd0;
            src_byte_en[8*f +: 8] = 8'd0;
         end
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present each feed's words, advance on valid&ready, check 1-cycle latency
   task automatic run_feeds(input int max_cyc);
      int    n;
      logic  acc [N];
      word_t w;
      n = 0;
      w = '0;
      while (remaining() > 0 && n < max_cyc) begin
         drive();
         @(negedge clk);
         for (int f = 0; f < N; f++) begin
            acc[f] = src_valid[f] && src_ready[f];
            if (acc[f]) begin
               acc_log.push_back(f);
               w = fmem[f][fptr[f]];
            end
         end
         @(posedge clk);
         #1;
         for (int f = 0; f < N; f++) begin
            if (acc[f]) begin
               fptr[f]++;
               check_eq("latency_vld", 72'(par_data_valid), 72'(1));
               check_eq("latency_word", {par_bytes, par_byte_en}, {w.b, w.be});
            end
         end
         n++;
      end
      check_eq("feed_budget", 72'(remaining()), 72'(0));
      drive();
   endtask

   task automatic compare_rx();
      check_eq("rx_count", 72'(rx_q.size()), 72'(exp_q.size()));
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         check_eq("rx_word", rx_q[i], exp_q[i]);
      check_eq("order_count", 72'(acc_log.size()), 72'(exp_ord.size()));
      for (int i = 0; i < acc_log.size() && i < exp_ord.size(); i++)
         check_eq("grant_order", 72'(acc_log[i]), 72'(exp_ord[i]));
   endtask

   initial begin
      rst_n       = 1'b0;
      par_ready   = 1'b1;
      src_valid   = '0;
      src_last    = '0;
      src_bytes   = '0;
      src_byte_en = '0;
      held        = '0;
      clear_all();

      // Reset state
      wait_cycles(3);
      check_eq("rst_pdv",   72'(par_data_valid), 72'(0));
      check_eq("rst_bytes", {par_bytes, par_byte_en}, 72'(0));
      check_eq("rst_busy",  72'(busy), 72'(0));
      check_eq("rst_gid",   72'(grant_id), 72'(0));
      check_eq("rst_ready", 72'(src_ready), 72'(0));
      check_eq("rst_lcnt",  72'(len_err_cnt), 72'(0));
      check_eq("rst_tcnt",  72'(timeout_err_cnt), 72'(0));
      rst_n = 1'b1;
      wait_cycles(2);

      // All four feeds at once: whole packets in order 0,1,2,3
      clear_all();
      for (int f = 0; f < N; f++) pkt14(f);
      for (int f = 0; f < N; f++) exp_for(f);
      run_feeds(200);
      wait_cycles(3);
      compare_rx();
      check_eq("rr_len_pulses", 72'(len_pulses), 72'(0));
      check_eq("rr_gid", 72'(grant_id), 72'(3));

      // Feeds 1 and 3 together: 1 then 3
      clear_all();
      pkt14(3);
      pkt14(1);
      exp_for(1);
      exp_for(3);
      run_feeds(200);
      wait_cycles(3);
      compare_rx();

      // Single feed, reference words
      clear_all();
      put(0, 64'h0e00010102000000, 8'hFF, 1'b0);
      put(0, 64'h062020d206000000, 8'hFC, 1'b1);
      exp_for(0);
      run_feeds(100);
      wait_cycles(3);
      compare_rx();
      check_eq("basic_len_pulses", 72'(len_pulses), 72'(0));
      check_eq("basic_gid", 72'(grant_id), 72'(0));
      check_eq("basic_busy", 72'(busy), 72'(0));

      // Parser back-pressure for 5 cycles mid-packet
      clear_all();
      put(0, {8'h18, 8'h00, 48'h000000000001}, 8'hFF, 1'b0);
      put(0, 64'h3333333333333333, 8'hFF, 1'b0);
      put(0, 64'h4444444444444444, 8'hFF, 1'b1);
      exp_for(0);
      fork
         run_feeds(200);
         begin
            repeat (2) @(posedge clk);
            #1;
            par_ready = 1'b0;
            held      = {par_bytes, par_byte_en};
            check_eq("stall_held_word", held, {64'h1800000000000001, 8'hFF});
            repeat (5) begin
               @(negedge clk);
               check_eq("stall_pdv", 72'(par_data_valid), 72'(1));
               check_eq("stall_stable", {par_bytes, par_byte_en}, held);
               check_eq("stall_ready", 72'(src_ready[0]), 72'(0));
               @(posedge clk);
               #1;
            end
            par_ready = 1'b1;
         end
      join
      wait_cycles(3);
      compare_rx();
      check_eq("stall_len_pulses", 72'(len_pulses), 72'(0));

      // Header says 14 bytes, 16 delivered
      clear_all();
      put(2, {8'h0e, 8'h00, 48'h000000002222}, 8'hFF, 1'b0);
      put(2, 64'h5555555555555555, 8'hFF, 1'b1);
      exp_for(2);
      run_feeds(100);
      wait_cycles(3);
      compare_rx();
      check_eq("lenerr_pulses", 72'(len_pulses), 72'(1));
      check_eq("lenerr_cnt", 72'(len_err_cnt), 72'(1));

      // Feed 3 stalls after its first word while feed 1 waits
      clear_all();
      put(3, {8'h20, 8'h00, 48'h000000007777}, 8'hFF, 1'b0);
      pkt14(1);
      exp_for(3);
      exp_for(1);
      run_feeds(400);
      wait_cycles(3);
      compare_rx();
      check_eq("to_pulses", 72'(to_pulses), 72'(1));
      check_eq("to_cnt", 72'(timeout_err_cnt), 72'(1));
      check_eq("to_busy", 72'(busy_at_to), 72'(0));
      if (rx_cyc.size() > 0)
         check_eq("to_gap", 72'(to_cyc - rx_cyc[0]), 72'(TO));
      else
         check_eq("to_gap_rx", 72'(rx_cyc.size()), 72'(1));
      check_eq("to_gid", 72'(grant_id), 72'(1));
      check_eq("to_lcnt_kept", 72'(len_err_cnt), 72'(1));

      // Reset in the middle of a feed-1 packet
      clear_all();
      put(1, {8'h18, 8'h00, 48'h000000008888}, 8'hFF, 1'b0);
      put(1, 64'h9999999999999999, 8'hFF, 1'b0);
      put(1, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b1);
      drive();
      wait_cycles(2);
      check_eq("pre_rst_gid", 72'(grant_id), 72'(1));
      check_eq("pre_rst_pdv", 72'(par_data_valid), 72'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_pdv",   72'(par_data_valid), 72'(0));
      check_eq("mid_rst_bytes", {par_bytes, par_byte_en}, 72'(0));
      check_eq("mid_rst_busy",  72'(busy), 72'(0));
      check_eq("mid_rst_gid",   72'(grant_id), 72'(0));
      check_eq("mid_rst_ready", 72'(src_ready), 72'(0));
      check_eq("mid_rst_lcnt",  72'(len_err_cnt), 72'(0));
      check_eq("mid_rst_tcnt",  72'(timeout_err_cnt), 72'(0));
      clear_all();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cycles(2);
      clear_all();
      pkt14(1);
      pkt14(0);
      exp_for(0);
      exp_for(1);
      run_feeds(100);
      wait_cycles(3);
      compare_rx();
      check_eq("post_rst_len_pulses", 72'(len_pulses), 72'(0));
      check_eq("post_rst_to_pulses", 72'(to_pulses), 72'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
